// File: rtl/output_pkg.sv
// Shared types for the output collector: one FIFO entry per controller capture
// and the serializer state encoding.
package output_pkg;

    localparam int OC_DATA_WIDTH         = 32;
    localparam int OC_COORD_WIDTH        = 32;
    localparam int OC_LANES              = 3;
    localparam int OC_DEPTH              = 8;
    localparam int OC_OUTPUT_NB_CHANNELS = 32;

    // data[0] is lane 0 and sits in the LSBs, matching the packed in_data bus.
    typedef struct packed {
        logic [OC_COORD_WIDTH-1:0]                   x;
        logic [OC_COORD_WIDTH-1:0]                   y;
        logic [OC_COORD_WIDTH-1:0]                   ch;
        logic [OC_LANES-1:0][OC_DATA_WIDTH-1:0]      data;
    } out_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } oc_state_t;

endpackage

// File: rtl/output_fifo.sv
// Capture FIFO: DEPTH entries of out_entry_t with simultaneous push/pop.
// Also exposes the entry behind the head so the serializer can chain without a bubble.
module output_fifo
    import output_pkg::*;
#(
    parameter int DEPTH = OC_DEPTH
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     push,
    input  out_entry_t               wr_entry,
    input  logic                     pop,
    output out_entry_t               head,
    output out_entry_t               next_head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] rd_idx_next;
    logic          push_ok;
    logic          pop_ok;
    out_entry_t    mem [DEPTH];

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign level       = wr_ptr - rd_ptr;
    assign pop_ok      = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok     = push && (!full || pop_ok);
    assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);
    assign head        = mem[rd_ptr[AW-1:0]];
    assign next_head   = mem[rd_idx_next];

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/output_collector.sv
// Buffers controller captures and serialises each into per-channel beats on a
// valid/ready host port; beats whose channel is out of range are skipped.
module output_collector
    import output_pkg::*;
#(
    parameter int DATA_WIDTH         = OC_DATA_WIDTH,
    parameter int COORD_WIDTH        = OC_COORD_WIDTH,
    parameter int LANES              = OC_LANES,
    parameter int DEPTH              = OC_DEPTH,
    parameter int OUTPUT_NB_CHANNELS = OC_OUTPUT_NB_CHANNELS
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        in_valid,
    input  logic [COORD_WIDTH-1:0]      in_x,
    input  logic [COORD_WIDTH-1:0]      in_y,
    input  logic [COORD_WIDTH-1:0]      in_ch,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [COORD_WIDTH-1:0]      out_x,
    output logic [COORD_WIDTH-1:0]      out_y,
    output logic [COORD_WIDTH-1:0]      out_ch,
    output logic                        almost_full,
    output logic                        empty,
    output logic                        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LANES+1);

    // Host handshake: a beat transfers on every clk edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 all out_* hold.

    oc_state_t                          state;
    logic [LW-1:0]                      lane;
    logic [LW-1:0]                      lane_inc;
    logic [COORD_WIDTH-1:0]             cur_ch;
    logic [LANES-1:0][DATA_WIDTH-1:0]   cur_data;

    out_entry_t      wr_entry;
    out_entry_t      head;
    out_entry_t      next_head;
    out_entry_t      load_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     level;
    logic [AW:0]     level_next;
    logic            hs;
    logic            has_next;
    logic            pop;
    logic            push_acc;
    logic            refill;
    logic            load_en;

    assign wr_entry.x    = in_x;
    assign wr_entry.y    = in_y;
    assign wr_entry.ch   = in_ch;
    assign wr_entry.data = in_data;

    output_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .push      (in_valid),
        .wr_entry  (wr_entry),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign hs       = (state == EMIT) && out_valid && out_ready;
    assign lane_inc = lane + LW'(1);
    // Channel compare is one bit wider so a base near the top cannot wrap into range.
    assign has_next = (int'(lane_inc) < LANES) &&
                      (({1'b0, cur_ch} + (COORD_WIDTH+1)'(lane_inc)) <
                       (COORD_WIDTH+1)'(OUTPUT_NB_CHANNELS));
    assign pop      = hs && !has_next;
    assign push_acc = in_valid && (!fifo_full || pop);
    assign refill   = (level > (AW+1)'(1)) || push_acc;
    assign load_en  = ((state == IDLE) && !fifo_empty) || (pop && refill);
    // With only the popped head stored, the chained entry is the one being written now.
    assign load_entry = (state == IDLE)           ? head      :
                        (level > (AW+1)'(1))      ? next_head : wr_entry;
    assign level_next = level + (AW+1)'(push_acc) - (AW+1)'(pop);
    assign empty      = fifo_empty && (state == IDLE);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state       <= IDLE;
            lane        <= '0;
            cur_ch      <= '0;
            cur_data    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_ch      <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            almost_full <= (level_next >= (AW+1)'(DEPTH-2));
            if (in_valid && !push_acc) overflow <= 1'b1;

            if (load_en) begin
                state     <= EMIT;
                lane      <= '0;
                cur_ch    <= load_entry.ch;
                cur_data  <= load_entry.data;
                out_valid <= 1'b1;
                out_data  <= load_entry.data[0];
                out_x     <= load_entry.x;
                out_y     <= load_entry.y;
                out_ch    <= load_entry.ch;
            end else if (hs && has_next) begin
                lane     <= lane_inc;
                out_data <= cur_data[lane_inc];
                out_ch   <= cur_ch + COORD_WIDTH'(lane_inc);
            end else if (pop) begin
                state     <= IDLE;
                lane      <= '0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector: hand-built capture vectors, an expected
// beat queue filled by a small lane-skip model, and a handshake monitor.
module tb_output_collector;

    logic        clk;
    logic        arst_n_in;
    logic        in_valid;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_ch;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_ch;
    logic        almost_full;
    logic        empty;
    logic        overflow;

    logic [127:0] exp_q[$];
    int           errors;
    int           checks;
    int           beats;

    output_collector dut (
        .clk         (clk),
        .arst_n_in   (arst_n_in),
        .in_valid    (in_valid),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_ch       (in_ch),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_ch      (out_ch),
        .almost_full (almost_full),
        .empty       (empty),
        .overflow    (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n_in = 1'b0;
        in_valid  = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        arst_n_in = 1'b1;
        tick();
    endtask

    // driver: one capture cycle; model adds the beats it must produce if accepted
    task automatic capture(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ch,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input bit accept);
        logic [31:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_ch    = ch;
        in_data  = {d2, d1, d0};
        if (accept) begin
            for (int l = 0; l < 3; l++) begin
                if (l == 0 || (33'(ch) + 33'(l)) < 33'd32)
                    exp_q.push_back({x, y, ch + 32'(l), d[l]});
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
        check({tag, "_empty"}, 128'(empty), 128'd1);
        check({tag, "_valid"}, 128'(out_valid), 128'd0);
    endtask

    // scoreboard: every handshake must match the head of the expected queue
    always @(negedge clk) begin
        if (arst_n_in && out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0)
                check("unexpected_beat", {out_x, out_y, out_ch, out_data}, 128'd0);
            else
                check("beat", {out_x, out_y, out_ch, out_data}, exp_q.pop_front());
        end
    end

    initial begin
        errors    = 0;
        checks    = 0;
        beats     = 0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_ch     = '0;
        in_data   = '0;
        out_ready = 1'b1;
        do_reset();

        // reset state
        check("rst_valid",    128'(out_valid),   128'd0);
        check("rst_fields",   {out_x, out_y, out_ch, out_data}, 128'd0);
        check("rst_afull",    128'(almost_full), 128'd0);
        check("rst_empty",    128'(empty),       128'd1);
        check("rst_overflow", 128'(overflow),    128'd0);

        // single capture: latency 2, then 3 back-to-back beats
        capture(5, 7, 0, 10, 20, 30, 1'b1);
        check("lat_cycle1", 128'(out_valid), 128'd0);
        check("lat_empty",  128'(empty),     128'd0);
        tick();
        check("lat_cycle2", 128'(out_valid), 128'd1);
        repeat (3) tick();
        check("single_done", 128'(exp_q.size()), 128'd0);
        check("single_empty", 128'(empty), 128'd1);

        // lane skip at the channel boundary: ch30, ch31 only
        beats = 0;
        capture(1, 2, 30, 100, 200, 300, 1'b1);
        drain("skip");
        check("skip_beats", 128'(beats), 128'd2);

        // stall: outputs held for 10 cycles with out_ready low
        out_ready = 1'b0;
        capture(3, 4, 4, 1, 2, 3, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 128'(out_valid), 128'd1);
            check("stall_hold", {out_x, out_y, out_ch, out_data}, exp_q[0]);
        end
        out_ready = 1'b1;
        drain("stall");

        // fill to full with the host stalled, then overflow on the 9th capture
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            capture(32'(i), 32'(100 + i), 0, 32'(i * 3 + 1), 32'(i * 3 + 2), 32'(i * 3 + 3), 1'b1);
            check($sformatf("afull_%0d", i + 1), 128'(almost_full), 128'(i >= 5));
            check($sformatf("no_ovf_%0d", i + 1), 128'(overflow), 128'd0);
        end
        capture(99, 99, 0, 777, 888, 999, 1'b0);
        check("ovf_set", 128'(overflow), 128'd1);
        out_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", 128'(overflow), 128'd1);
        check("ovf_afull_low", 128'(almost_full), 128'd0);

        // full FIFO, push coincides with the head's last-lane handshake
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            capture(32'(i), 32'(200 + i), 0, 32'(50 + i), 32'(60 + i), 32'(70 + i), 1'b1);
        out_ready = 1'b1;
        tick();
        tick();
        capture(42, 43, 0, 500, 600, 700, 1'b1);
        check("edge_no_ovf", 128'(overflow), 128'd0);
        drain("edge");
        check("edge_no_ovf_end", 128'(overflow), 128'd0);

        // asynchronous reset mid-emit with 3 entries queued
        do_reset();
        out_ready = 1'b0;
        capture(1, 1, 0, 11, 12, 13, 1'b1);
        capture(2, 2, 0, 21, 22, 23, 1'b1);
        capture(3, 3, 0, 31, 32, 33, 1'b1);
        tick();
        check("pre_rst_valid", 128'(out_valid), 128'd1);
        #2;
        arst_n_in = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_empty", 128'(empty),     128'd1);
        exp_q.delete();
        tick();
        arst_n_in = 1'b1;
        tick();
        out_ready = 1'b1;
        capture(8, 9, 10, 1000, 2000, 3000, 1'b1);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
